// File: rtl/branch_redirect_unit_if.sv
// EX-to-fetch redirect bus: EX branch/jump decision inputs, the redirect handshake,
// the flush/stall controls and the optional misalignment trap report.
interface branch_redirect_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic            branch_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            redirect_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall_ex;
  logic            flush_ifid;
  logic            flush_idex;
  logic [CNT_W-1:0] redirect_cnt;
  logic            misalign_trap;
  logic [XLEN-1:0] misalign_addr;

  // Redirect unit side
  modport master (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken,
    input  ex_pc, ex_imm, ex_rs1, redirect_ready,
    output redirect_valid, redirect_pc, stall_ex, flush_ifid, flush_idex,
    output redirect_cnt, misalign_trap, misalign_addr
  );

  // Pipeline / fetch side
  modport slave (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken,
    output ex_pc, ex_imm, ex_rs1, redirect_ready,
    input  redirect_valid, redirect_pc, stall_ex, flush_ifid, flush_idex,
    input  redirect_cnt, misalign_trap, misalign_addr
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Turns taken EX branches/jumps into a registered fetch redirect plus wrong-path flushes.
// Optional macro BR_MISALIGN_TRAP_EN: misaligned targets raise a trap instead of redirecting.
module branch_redirect_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst,
  branch_redirect_unit_if.master bus
);

  localparam int unsigned FC_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, stall_q, flush_ifid_q, flush_idex_q;

  logic             event_c;
  logic             misaligned_c;
  logic [XLEN-1:0]  target_c;

  // Event detection and target arithmetic (jalr wins over jal/branch)
  always_comb begin
    event_c = bus.ex_valid &
              ((bus.ex_is_branch & bus.branch_taken) | bus.ex_is_jal | bus.ex_is_jalr);
    if (bus.ex_is_jalr) begin
      target_c = (bus.ex_rs1 + bus.ex_imm) & ~XLEN'(1);
    end else begin
      target_c = bus.ex_pc + bus.ex_imm;
    end
  end

`ifdef BR_MISALIGN_TRAP_EN
  assign misaligned_c = |target_c[1:0];
`else
  assign misaligned_c = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (event_c && !misaligned_c) begin
          pc_d    = target_c;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        if (fcnt_q <= FC_W'(1)) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      pc_q         <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      stall_q      <= 1'b0;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      valid_q      <= (state_d == REDIRECT);
      stall_q      <= (state_d == REDIRECT);
      flush_idex_q <= (state_d == REDIRECT);
      flush_ifid_q <= (state_d != IDLE);
    end
  end

  assign bus.redirect_valid = valid_q;
  assign bus.redirect_pc    = pc_q;
  assign bus.stall_ex       = stall_q;
  assign bus.flush_ifid     = flush_ifid_q;
  assign bus.flush_idex     = flush_idex_q;
  assign bus.redirect_cnt   = cnt_q;

`ifdef BR_MISALIGN_TRAP_EN
  logic            trap_q;
  logic [XLEN-1:0] maddr_q;

  // Misaligned target in IDLE: one-cycle trap pulse, address held for the handler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      trap_q <= (state_q == IDLE) && event_c && misaligned_c;
      if ((state_q == IDLE) && event_c && misaligned_c) begin
        maddr_q <= target_c;
      end
    end
  end

  assign bus.misalign_trap = trap_q;
  assign bus.misalign_addr = maddr_q;
`else
  assign bus.misalign_trap = 1'b0;
  assign bus.misalign_addr = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: main instance (FLUSH_CYCLES=1) plus a small-counter
// instance (CNT_W=3, FLUSH_CYCLES=0) for saturation and the no-flush path.
module tb_branch_redirect_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FC   = 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [XLEN-1:0] exp_pc;
  logic [15:0]     exp_cnt;

  branch_redirect_unit_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
  branch_redirect_unit_if #(.XLEN(XLEN), .CNT_W(3))  sbus ();

  branch_redirect_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  branch_redirect_unit #(.XLEN(XLEN), .FLUSH_CYCLES(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .bus(sbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_is_jal = 1'b0;
    bus.ex_is_jalr = 1'b0; bus.branch_taken = 1'b0;
    bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_rs1 = '0;
  endtask

  task automatic present(input logic br, input logic tk, input logic jal, input logic jalr,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                         input logic [XLEN-1:0] rs1);
    bus.ex_valid = 1'b1; bus.ex_is_branch = br; bus.branch_taken = tk;
    bus.ex_is_jal = jal; bus.ex_is_jalr = jalr;
    bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_rs1 = rs1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.redirect_valid); end
    n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.redirect_pc); end
    n_cmp++; if ({bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b want 000", {bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
    n_cmp++; if (bus.redirect_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", bus.redirect_cnt); end
    n_cmp++; if (bus.misalign_trap !== 1'b0) begin n_err++; $display("FAIL reset_trap got %b want 0", bus.misalign_trap); end
  endtask

  task automatic test_beq_taken();
    bus.redirect_ready = 1'b1;
    present(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
    tick();
    clear_ex();
    exp_pc = 32'h120;
    n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid got %b want 1", bus.redirect_valid); end
    n_cmp++; if (bus.redirect_pc !== exp_pc) begin n_err++; $display("FAIL beq_pc got %h want %h", bus.redirect_pc, exp_pc); end
    n_cmp++; if ({bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 3'b111) begin n_err++; $display("FAIL beq_ctl got %b want 111", {bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
    tick();
    exp_cnt = 16'd1;
    n_cmp++; if (bus.redirect_cnt !== exp_cnt) begin n_err++; $display("FAIL beq_cnt got %h want %h", bus.redirect_cnt, exp_cnt); end
    n_cmp++; if ({bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 4'b0010) begin n_err++; $display("FAIL beq_flush got %b want 0010", {bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
    tick();
    n_cmp++; if (bus.flush_ifid !== 1'b0) begin n_err++; $display("FAIL beq_idle got %b want 0", bus.flush_ifid); end
    bus.redirect_ready = 1'b0;
  endtask

  task automatic test_jalr();
    // jal also set: jalr target must win
    present(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h4, 32'h1003);
    tick();
    clear_ex();
`ifdef BR_MISALIGN_TRAP_EN
    n_cmp++; if (bus.misalign_trap !== 1'b1) begin n_err++; $display("FAIL jalr_trap got %b want 1", bus.misalign_trap); end
    n_cmp++; if (bus.misalign_addr !== 32'h1006) begin n_err++; $display("FAIL jalr_maddr got %h want 00001006", bus.misalign_addr); end
    n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL jalr_novalid got %b want 0", bus.redirect_valid); end
    tick();
    n_cmp++; if (bus.misalign_trap !== 1'b0) begin n_err++; $display("FAIL jalr_pulse got %b want 0", bus.misalign_trap); end
    n_cmp++; if (bus.redirect_cnt !== exp_cnt) begin n_err++; $display("FAIL jalr_cnt got %h want %h", bus.redirect_cnt, exp_cnt); end
`else
    exp_pc = 32'h1006;
    n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL jalr_valid got %b want 1", bus.redirect_valid); end
    n_cmp++; if (bus.redirect_pc !== exp_pc) begin n_err++; $display("FAIL jalr_pc got %h want %h", bus.redirect_pc, exp_pc); end
    n_cmp++; if (bus.misalign_trap !== 1'b0) begin n_err++; $display("FAIL jalr_notrap got %b want 0", bus.misalign_trap); end
    bus.redirect_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (bus.redirect_cnt !== exp_cnt) begin n_err++; $display("FAIL jalr_cnt got %h want %h", bus.redirect_cnt, exp_cnt); end
    bus.redirect_ready = 1'b0;
    tick();
`endif
  endtask

  task automatic test_not_taken();
    // ready high while nothing is pending must not count
    bus.redirect_ready = 1'b1;
    present(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 4'b0000) begin n_err++; $display("FAIL nt_ctl[%0d] got %b want 0000", i, {bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
    end
    n_cmp++; if (bus.redirect_pc !== exp_pc) begin n_err++; $display("FAIL nt_pc got %h want %h", bus.redirect_pc, exp_pc); end
    present(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40, 32'h0);
    bus.ex_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL nv_valid got %b want 0", bus.redirect_valid); end
    n_cmp++; if (bus.redirect_cnt !== exp_cnt) begin n_err++; $display("FAIL nt_cnt got %h want %h", bus.redirect_cnt, exp_cnt); end
    clear_ex();
    bus.redirect_ready = 1'b0;
  endtask

  task automatic test_jal_stall();
    bus.redirect_ready = 1'b0;
    present(1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h40, 32'h0);
    tick();
    exp_pc = 32'h2040;
    // a different event while busy must be ignored
    present(1'b0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h8, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 4'b1111) begin n_err++; $display("FAIL hold_ctl[%0d] got %b want 1111", i, {bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
      n_cmp++; if (bus.redirect_pc !== exp_pc) begin n_err++; $display("FAIL hold_pc[%0d] got %h want %h", i, bus.redirect_pc, exp_pc); end
      tick();
    end
    clear_ex();
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (bus.redirect_cnt !== exp_cnt) begin n_err++; $display("FAIL jal_cnt got %h want %h", bus.redirect_cnt, exp_cnt); end
    for (int i = 0; i < int'(FC); i++) begin
      n_cmp++; if ({bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 4'b0010) begin n_err++; $display("FAIL flush_ctl[%0d] got %b want 0010", i, {bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
      tick();
    end
    n_cmp++; if ({bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 4'b0000) begin n_err++; $display("FAIL flush_end got %b want 0000", {bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
  endtask

  task automatic test_wrap();
    bus.redirect_ready = 1'b1;
    present(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    tick();
    clear_ex();
    n_cmp++; if (bus.redirect_pc !== 32'h0000_0010) begin n_err++; $display("FAIL wrap_pc got %h want 00000010", bus.redirect_pc); end
    tick(); tick();
    bus.redirect_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [2:0] sexp;
    sexp = 3'd0;
    sbus.redirect_ready = 1'b1;
    sbus.ex_valid = 1'b1; sbus.ex_is_jal = 1'b1;
    sbus.ex_pc = 32'h40; sbus.ex_imm = 32'h8;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++; if ({sbus.redirect_valid, sbus.redirect_pc} !== {1'b1, 32'h48}) begin n_err++; $display("FAIL sat_req[%0d] got %b/%h want 1/00000048", i, sbus.redirect_valid, sbus.redirect_pc); end
      tick();
      if (sexp != 3'd7) sexp = sexp + 3'd1;
      n_cmp++; if (sbus.redirect_cnt !== sexp) begin n_err++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, sbus.redirect_cnt, sexp); end
      n_cmp++; if ({sbus.redirect_valid, sbus.flush_ifid} !== 2'b00) begin n_err++; $display("FAIL sat_noflush[%0d] got %b want 00", i, {sbus.redirect_valid, sbus.flush_ifid}); end
    end
    sbus.ex_valid = 1'b0; sbus.ex_is_jal = 1'b0;
    sbus.redirect_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.redirect_ready = 1'b0;
    present(1'b0, 1'b0, 1'b1, 1'b0, 32'h4000, 32'h10, 32'h0);
    tick();
    clear_ex();
    n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre got %b want 1", bus.redirect_valid); end
    #2;
    rst = 1'b1;
    bus.redirect_ready = 1'b1;
    #1;
    n_cmp++; if ({bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex} !== 4'b0000) begin n_err++; $display("FAIL rm_ctl got %b want 0000", {bus.redirect_valid, bus.stall_ex, bus.flush_ifid, bus.flush_idex}); end
    n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_err++; $display("FAIL rm_pc got %h want 0", bus.redirect_pc); end
    n_cmp++; if (bus.redirect_cnt !== 16'h0) begin n_err++; $display("FAIL rm_cnt got %h want 0", bus.redirect_cnt); end
    tick();
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.redirect_valid, bus.flush_ifid} !== 2'b00) begin n_err++; $display("FAIL rm_idle got %b want 00", {bus.redirect_valid, bus.flush_ifid}); end
    n_cmp++; if (bus.redirect_cnt !== 16'h0) begin n_err++; $display("FAIL rm_nocount got %h want 0", bus.redirect_cnt); end
    bus.redirect_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pc = '0;
    exp_cnt = '0;
    rst = 1'b1;
    clear_ex();
    bus.redirect_ready = 1'b0;
    sbus.ex_valid = 1'b0; sbus.ex_is_branch = 1'b0; sbus.ex_is_jal = 1'b0;
    sbus.ex_is_jalr = 1'b0; sbus.branch_taken = 1'b0;
    sbus.ex_pc = '0; sbus.ex_imm = '0; sbus.ex_rs1 = '0;
    sbus.redirect_ready = 1'b0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_beq_taken();
    test_jalr();
    test_not_taken();
    test_jal_stall();
    test_wrap();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
